// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory arbiter.
//   DATA_W        data word width
//   DEPTH_DEF     default number of RAM words
//   MAX_WAIT_DEF  default debug starvation limit (cycles)
//   WAIT_W        width of the debug wait counter (holds 1..15)
//   dump_state_e  dump sequencer states
//   rd_tag_t      owner/attributes of a read in flight (one RAM latency stage)
package dmem_pkg;
   localparam int DATA_W       = 32;
   localparam int DEPTH_DEF    = 512;
   localparam int MAX_WAIT_DEF = 4;
   localparam int WAIT_W       = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } dump_state_e;

   typedef struct packed {
      logic cpu;   // CPU load returns next cycle
      logic dbg;   // debug read returns next cycle
      logic dump;  // dump beat returns next cycle
      logic oob;   // address was outside the RAM, force data to 0
   } rd_tag_t;
endpackage

// File: rtl/dmem_dump_seq.sv
// dmem_dump_seq: memory dump sequencer. Walks addresses 0..DEPTH-1, one read
// per cycle while in READ, then DRAIN (last beat returns) and a DONE pulse.
//   clock, rst_n  clock, synchronous active-low reset
//   start         dump request, only honoured in IDLE
//   rd_en         sequencer owns the RAM slot this cycle
//   rd_addr       address being read when rd_en is high
//   busy          high in READ and DRAIN
//   done          one-cycle pulse in DONE
module dmem_dump_seq
   import dmem_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = 9
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              busy,
   output logic              done
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   dump_state_e       state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state <= IDLE;
         addr  <= '0;
      end else begin
         state <= state_nxt;
         addr  <= addr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      rd_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = READ;
               addr_nxt  = '0;
            end
         end
         READ: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            // stop on the last word instead of incrementing, so the counter never wraps
            if (addr == LAST) state_nxt = DRAIN;
            else              addr_nxt  = addr + ADDR_W'(1);
         end
         DRAIN: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_addr = addr;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates one single-port data RAM (1-cycle read latency)
// between the CPU MEM stage, a debug port and the memory dump engine.
//   clock, rst_n        clock, synchronous active-low reset
//   cpu_*               CPU request (req/we/addr/wdata), load data, stall
//   dbg_*               debug request, combinational grant, read response
//   dump_*              dump start, busy/done status, read beats (valid/addr/data)
//   ram_*               RAM port (en/we/addr/wdata out, rdata in)
// CPU wins by default; debug wins when the CPU is idle or after waiting
// MAX_WAIT cycles. While the dump reads, it owns the RAM outright.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR_W   = 9,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   input  logic              dump_start,
   output logic              dump_busy,
   output logic              dump_valid,
   output logic              dump_done,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

   function automatic logic is_oob(input logic [ADDR_W-1:0] a);
      return 32'(a) >= 32'(DEPTH);
   endfunction

   logic [WAIT_W-1:0] wait_cnt;
   logic              seq_rd, seq_busy, seq_done;
   logic [ADDR_W-1:0] seq_addr;
   logic              dump_gnt, dbg_win, cpu_gnt, sel_we, oob;
   logic [ADDR_W-1:0] sel_addr;
   rd_tag_t           tag_d, tag_q;
   logic [ADDR_W-1:0] dump_addr_q;
   logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q, rd_data;

   dmem_dump_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
      .clock   (clock),
      .rst_n   (rst_n),
      .start   (dump_start),
      .rd_en   (seq_rd),
      .rd_addr (seq_addr),
      .busy    (seq_busy),
      .done    (seq_done)
   );

   // Grant priority: dump (READ) > starved or uncontended debug > CPU.
   // Everything is qualified with rst_n so no access leaks out during reset.
   always_comb begin
      dump_gnt = 1'b0;
      dbg_win  = 1'b0;
      cpu_gnt  = 1'b0;
      if (rst_n) begin
         if (seq_rd)                                          dump_gnt = 1'b1;
         else if (dbg_req && (!cpu_req || wait_cnt == WAIT_LIM)) dbg_win  = 1'b1;
         else if (cpu_req)                                    cpu_gnt  = 1'b1;
      end
   end

   always_comb begin
      sel_addr = cpu_addr;
      sel_we   = cpu_gnt & cpu_we;
      if (dump_gnt) begin
         sel_addr = seq_addr;
         sel_we   = 1'b0;
      end else if (dbg_win) begin
         sel_addr = dbg_addr;
         sel_we   = dbg_we;
      end
   end

   assign oob       = is_oob(sel_addr);
   assign ram_en    = dump_gnt | dbg_win | cpu_gnt;
   assign ram_we    = ram_en & sel_we & ~oob;
   assign ram_addr  = sel_addr;
   assign ram_wdata = dbg_win ? dbg_wdata : cpu_wdata;

   always_comb begin
      tag_d      = '0;
      tag_d.cpu  = cpu_gnt & ~cpu_we;
      tag_d.dbg  = dbg_win & ~dbg_we;
      tag_d.dump = dump_gnt;
      tag_d.oob  = oob;
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         tag_q       <= '0;
         wait_cnt    <= '0;
         dump_addr_q <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         tag_q <= tag_d;
         // saturate at the limit so a debug request held through a dump
         // is still granted as soon as the dump releases the RAM
         if (!dbg_req || dbg_win)    wait_cnt <= '0;
         else if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + WAIT_W'(1);
         if (dump_gnt)  dump_addr_q <= seq_addr;
         if (tag_q.cpu) cpu_rdata_q <= rd_data;
         if (tag_q.dbg) dbg_rdata_q <= rd_data;
      end
   end

   // Return data is passed through in the cycle it arrives, then held.
   assign rd_data    = tag_q.oob ? '0 : ram_rdata;
   assign cpu_rdata  = tag_q.cpu ? rd_data : cpu_rdata_q;
   assign dbg_rdata  = tag_q.dbg ? rd_data : dbg_rdata_q;
   assign cpu_stall  = rst_n & cpu_req & ~cpu_gnt;
   assign dbg_gnt    = dbg_win;
   assign dbg_rvalid = rst_n & tag_q.dbg;
   assign dump_valid = rst_n & tag_q.dump;
   assign dump_addr  = dump_addr_q;
   assign dump_data  = rd_data;
   assign dump_busy  = rst_n & seq_busy;
   assign dump_done  = rst_n & seq_done;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// single-port RAM (512 words, ADDR_W=10 so out-of-range addresses exist).
module tb_dmem_arbiter;
   localparam int DEPTH = 512;
   localparam int AW    = 10;

   logic          clock = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we, dbg_req, dbg_we, dump_start;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [31:0]   cpu_wdata, dbg_wdata;
   logic [31:0]   cpu_rdata, dbg_rdata, dump_data, ram_wdata, ram_rdata;
   logic          cpu_stall, dbg_gnt, dbg_rvalid, dump_busy, dump_valid, dump_done;
   logic          ram_en, ram_we;
   logic [AW-1:0] dump_addr, ram_addr;

   always #5 clock = ~clock;

   dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .MAX_WAIT(4)) dut (
      .clock(clock), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
      .dump_done(dump_done), .dump_addr(dump_addr), .dump_data(dump_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // RAM model; out-of-range reads return garbage so the DUT must mask them
   logic [31:0] mem [0:DEPTH-1];
   logic        preload = 1'b0;
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i * 3);
      end else if (ram_en) begin
         if (32'(ram_addr) < DEPTH) begin
            if (ram_we) mem[ram_addr[8:0]] <= ram_wdata;
            ram_rdata <= mem[ram_addr[8:0]];
         end else begin
            ram_rdata <= 32'hBAD0_BAD0;
         end
      end
   end

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   typedef struct { logic [AW-1:0] a; logic [31:0] d; } beat_t;
   logic [31:0] cpu_q [$];
   logic [31:0] dbg_q [$];
   beat_t       dump_q [$];
   int          n_beats = 0, n_done = 0;

   // response monitor: pops expectations as the DUT produces read data
   always @(negedge clock) begin
      if (rst_n) begin
         if (dbg_rvalid) begin
            if (dbg_q.size() == 0) chk("dbg_unexpected", 32'(dbg_rvalid), 0);
            else chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
         end
         if (dump_valid) begin
            n_beats++;
            if (dump_q.size() == 0) chk("dump_unexpected", 32'(dump_valid), 0);
            else begin
               beat_t b;
               b = dump_q.pop_front();
               chk("dump_addr", 32'(dump_addr), 32'(b.a));
               chk("dump_data", dump_data, b.d);
            end
         end
         if (dump_done) n_done++;
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_in();
      cpu_req = 0; cpu_we = 0; dbg_req = 0; dbg_we = 0; dump_start = 0;
   endtask

   task automatic push_dump();
      for (int i = 0; i < DEPTH; i++) begin
         beat_t b;
         b.a = AW'(i);
         b.d = 32'(i * 3);
         dump_q.push_back(b);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt, done0, found;
      rst_n = 0; idle_in();
      cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;
      // requests held during reset must not leak out
      cpu_req = 1; dbg_req = 1;
      repeat (3) cyc();
      @(negedge clock);
      chk("rst_stall", 32'(cpu_stall), 0);
      chk("rst_dbg_gnt", 32'(dbg_gnt), 0);
      chk("rst_ram_en", 32'(ram_en), 0);
      chk("rst_busy", 32'(dump_busy), 0);
      chk("rst_valid", 32'(dump_valid), 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);

      // CPU write then read-back, first cycle after reset release
      cyc(); rst_n = 1; idle_in();
      cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wdata = 32'hDEADBEEF;
      @(negedge clock);
      chk("wr_ram_en", 32'(ram_en), 1);
      chk("wr_ram_we", 32'(ram_we), 1);
      chk("wr_stall", 32'(cpu_stall), 0);
      cyc(); cpu_we = 0;
      @(negedge clock);
      chk("rd_stall", 32'(cpu_stall), 0);
      chk("rd_ram_we", 32'(ram_we), 0);
      cpu_q.push_back(32'hDEADBEEF);
      cyc(); idle_in();
      @(negedge clock);
      chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      chk("idle_stall", 32'(cpu_stall), 0);
      cyc();
      @(negedge clock);
      chk("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);

      // simultaneous request for one cycle: CPU wins, debug waits
      cyc(); cpu_req = 1; cpu_addr = 5; dbg_req = 1; dbg_addr = 7;
      @(negedge clock);
      chk("both_dbg_gnt", 32'(dbg_gnt), 0);
      chk("both_stall", 32'(cpu_stall), 0);
      chk("both_ram_addr", 32'(ram_addr), 5);
      cpu_q.push_back(32'hDEADBEEF);
      cyc(); idle_in();
      @(negedge clock);
      chk("wait_cnt_1", 32'(dut.wait_cnt), 1);
      chk("cpu_rdata2", cpu_rdata, cpu_q.pop_front());

      // lone debug write: granted immediately
      cyc(); dbg_req = 1; dbg_we = 1; dbg_addr = 9; dbg_wdata = 32'h12345678;
      @(negedge clock);
      chk("dbgw_gnt", 32'(dbg_gnt), 1);
      chk("dbgw_ram_we", 32'(ram_we), 1);

      // sustained contention: debug every 5th cycle
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (k == 0) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 5; dbg_we = 0; dbg_addr = 9;
         end
         @(negedge clock);
         chk($sformatf("cont_gnt_%0d", k), 32'(dbg_gnt), 32'(k % 5 == 4));
         chk($sformatf("cont_stall_%0d", k), 32'(cpu_stall), 32'(k % 5 == 4));
         chk($sformatf("cont_rv_%0d", k), 32'(dbg_rvalid), 32'(k > 0 && k % 5 == 0));
         if (k % 5 == 4) dbg_q.push_back(32'h12345678);
      end
      cyc(); idle_in();
      @(negedge clock);
      chk("cont_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

      // out-of-range accesses
      cyc(); dbg_req = 1; dbg_we = 1; dbg_addr = 600; dbg_wdata = 32'hAAAA5555;
      @(negedge clock);
      chk("oob_gnt", 32'(dbg_gnt), 1);
      chk("oob_ram_en", 32'(ram_en), 1);
      chk("oob_ram_we", 32'(ram_we), 0);
      cyc(); dbg_we = 0;
      @(negedge clock);
      chk("oob_rd_gnt", 32'(dbg_gnt), 1);
      dbg_q.push_back(32'h0);
      cyc(); idle_in(); cpu_req = 1; cpu_addr = 600;
      cpu_q.push_back(32'h0);
      cyc(); idle_in();
      @(negedge clock);
      chk("oob_cpu_rdata", cpu_rdata, cpu_q.pop_front());

      // full dump of preloaded RAM
      cyc(); preload = 1;
      cyc(); preload = 0;
      n_beats = 0; n_done = 0; busy_cnt = 0;
      cyc(); dump_start = 1; push_dump();
      @(negedge clock);
      chk("dump_idle_busy", 32'(dump_busy), 0);
      cyc(); dump_start = 0; cpu_req = 1; cpu_addr = 5; dbg_req = 1; dbg_addr = 9;
      for (int n = 0; n < 600; n++) begin
         @(negedge clock);
         if (dump_busy) busy_cnt++;
         if (n < 4) begin
            chk("dump_cpu_stall", 32'(cpu_stall), 1);
            chk("dump_dbg_gnt", 32'(dbg_gnt), 0);
         end
         cyc();
         if (n == 3) idle_in();
         dump_start = (n == 10);
      end
      idle_in();
      chk("dump_busy_cycles", 32'(busy_cnt), 513);
      chk("dump_beats", 32'(n_beats), 512);
      chk("dump_done_pulses", 32'(n_done), 1);
      chk("dump_q_empty", 32'(dump_q.size()), 0);

      // reset in the middle of a dump
      cyc(); dump_start = 1; push_dump();
      cyc(); dump_start = 0;
      found = 0;
      for (int n = 0; n < 300 && found == 0; n++) begin
         @(negedge clock);
         if (dump_valid && dump_addr == AW'(100)) found = 1;
         else cyc();
      end
      chk("abort_reach_100", 32'(found), 1);
      done0 = n_done;
      cyc(); rst_n = 0; cpu_req = 1; dump_q.delete();
      @(negedge clock);
      chk("abort_busy", 32'(dump_busy), 0);
      chk("abort_ram_en", 32'(ram_en), 0);
      chk("abort_stall", 32'(cpu_stall), 0);
      cyc(); rst_n = 1; idle_in();
      repeat (10) cyc();
      @(negedge clock);
      chk("abort_no_done", 32'(n_done), 32'(done0));
      chk("abort_idle_busy", 32'(dump_busy), 0);

      // restart runs the whole range again from address 0
      n_beats = 0; n_done = 0;
      cyc(); dump_start = 1; push_dump();
      cyc(); dump_start = 0;
      repeat (530) cyc();
      chk("restart_beats", 32'(n_beats), 512);
      chk("restart_done", 32'(n_done), 1);
      chk("restart_q_empty", 32'(dump_q.size()), 0);
      chk("dbg_q_empty", 32'(dbg_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 512, meaning number of 32-bit data-RAM words.
REQ-002 The block SHALL have parameter ADDR_W, default 9, meaning word-address width (log2 DEPTH).
REQ-003 The block SHALL have parameter MAX_WAIT, default 4, meaning debug starvation limit in cycles (range 1..15).
REQ-004 The block SHALL have the port clock, input, 1, the single clock; all logic on the rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1, a synchronous active-low reset.
REQ-006 The block SHALL have the ports cpu_req/cpu_we, input, 1 each, the MEM-stage access request and write enable.
REQ-007 The block SHALL have the ports cpu_addr, input, ADDR_W, and cpu_wdata, input, 32, the MEM-stage word address and store data.
REQ-008 The block SHALL have the ports cpu_rdata, output, 32, and cpu_stall, output, 1, the load data and the pipeline stall.
REQ-009 The block SHALL have the ports dbg_req/dbg_we, input, 1 each; dbg_addr, input, ADDR_W; dbg_wdata, input, 32; these form the debug access port.
REQ-010 The block SHALL have the ports dbg_gnt, output, 1; dbg_rvalid, output, 1; dbg_rdata, output, 32; these form the debug response.
REQ-011 The block SHALL have the ports dump_start, input, 1; dump_busy, dump_valid, dump_done, output, 1 each; dump_addr, output, ADDR_W; dump_data, output, 32; these form the memory dump engine.
REQ-012 The block SHALL have the ports ram_en/ram_we, output, 1 each; ram_addr, output, ADDR_W; ram_wdata, output, 32; ram_rdata, input, 32; these form the single-port RAM with 1-cycle synchronous read.

Function
REQ-013 The block SHALL grant exactly one RAM access per cycle; ram_en SHALL be high iff a grant is issued.
REQ-014 The CPU SHALL win by default; cpu_stall SHALL be 0 in any cycle the CPU is granted or not requesting.
REQ-015 A wait counter SHALL increment each cycle dbg_req is high and the debug port is not granted; it SHALL clear on debug grant or when dbg_req is low.
REQ-016 When the wait counter equals MAX_WAIT, debug SHALL be granted in that cycle; cpu_stall SHALL be high if cpu_req is high.
REQ-017 dbg_gnt SHALL be combinational in the grant cycle; a granted debug read SHALL return dbg_rdata with dbg_rvalid high exactly 1 cycle later.
REQ-018 A granted CPU read SHALL present ram_rdata on cpu_rdata 1 cycle later; cpu_rdata SHALL hold its value until the next CPU read returns.
REQ-019 Writes SHALL complete in the grant cycle; a read of the same address in the next cycle SHALL return the new data.
REQ-020 Addresses >= DEPTH SHALL be granted but write-suppressed (ram_we 0), and reads SHALL return 0.
REQ-021 The dump FSM SHALL have the states IDLE, READ, DRAIN and DONE.
REQ-022 IDLE->READ SHALL occur on dump_start; dump_start SHALL be ignored outside IDLE.
REQ-023 In READ the engine SHALL take the debug slot, keep dbg_gnt 0, and issue reads at addresses 0..DEPTH-1 in order, one per cycle it is granted.
REQ-024 In READ the CPU SHALL always be stalled if it is requesting, because the dump owns the RAM.
REQ-025 READ->DRAIN SHALL occur after address DEPTH-1 is issued; DRAIN->DONE SHALL occur after one cycle; DONE->IDLE SHALL occur after one cycle.
REQ-026 dump_valid SHALL pulse with dump_data/dump_addr 1 cycle after each read; there SHALL be exactly DEPTH valid beats in total, and the address counter SHALL not wrap.
REQ-027 dump_busy SHALL be high in READ and DRAIN; dump_done SHALL be a one-cycle pulse in DONE.

Reset
REQ-028 When rst_n is low at a clock edge, the FSM SHALL go to IDLE, and the wait counter, dump address, cpu_rdata and dbg_rdata SHALL clear to 0.
REQ-029 During reset, all 1-bit outputs SHALL be 0, and a reset mid-dump SHALL abort the dump without a dump_done pulse.
REQ-030 The first grant after reset SHALL be possible in the first cycle after rst_n rises.

Structure
REQ-031 The dump FSM state encoding and the defaults for DATA_W=32, DEPTH and MAX_WAIT SHALL reside in the shared package dmem_pkg.
REQ-032 The dump FSM with its address counter SHALL be the sub-module dmem_dump_seq, and grant logic SHALL stay in dmem_arbiter.

Verification
REQ-033 The bench SHALL drive a CPU write of 0xDEADBEEF to address 5, then a CPU read of 5 the next cycle -> cpu_rdata=0xDEADBEEF 1 cycle after grant, with cpu_stall 0 throughout.
REQ-034 The bench SHALL hold cpu_req and dbg_req high continuously (MAX_WAIT=4) -> debug granted on the 5th cycle, cpu_stall high that cycle only, then the pattern repeats.
REQ-035 The bench SHALL raise cpu_req and dbg_req together for one cycle -> CPU granted, dbg_gnt 0, and the wait counter at 1.
REQ-036 The bench SHALL preload word i with value i*3, then pulse dump_start -> 512 dump_valid beats with dump_data=dump_addr*3, dump_busy for 513 cycles, and one dump_done pulse.
REQ-037 The bench SHALL pull rst_n low at dump address 100 -> dump_busy 0 at the next edge, no dump_done, and a new dump_start restarting from address 0.
REQ-038 The bench SHALL issue a debug write to address 600 -> ram_we 0, and a debug read of 600 -> dbg_rdata 0.
